// File: rtl/mu0_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mu0_bus_pkg
//  Brief    : Shared types and constants for the MU0 memory-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mu0_bus_pkg;

   // Default bus geometry (word address, data width)
   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 16;

   // Arbiter ownership state
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,   // no owner
      ST_CORE     = 2'd1,   // last grant went to the core
      ST_DBG      = 2'd2,   // last grant went to the host, unlocked
      ST_DBG_LOCK = 2'd3    // host holds the bus
   } arb_state_t;

   // Tag identifying which requester an outstanding read belongs to
   typedef logic owner_t;
   localparam owner_t OWN_CORE = 1'b0;
   localparam owner_t OWN_DBG  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mu0_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mu0_mem_arbiter_if
//  Brief    : Core, debug-host and memory-port signals of the MU0 arbiter.
//             slave = arbiter side, master = requesters plus memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface mu0_mem_arbiter_if
   import mu0_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   // Core requester
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_gnt;
   logic              core_rvalid;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;

   // Debug / loader host
   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_lock;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   // MU0_Memory port 0
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_gnt, core_rvalid, core_rdata, core_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_gnt, core_rvalid, core_rdata, core_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );

endinterface
`default_nettype wire

// File: rtl/mu0_rd_return.sv
`default_nettype none
// ============================================================================
//  Module   : mu0_rd_return
//  Brief    : Read-return path. Remembers which requester issued the read in
//             the previous cycle and steers the memory read data to it; each
//             requester's rdata holds its last delivered word otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module mu0_rd_return
   import mu0_bus_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_rd_issue,
   input  wire owner_t            i_rd_owner,
   input  wire logic [DATA_W-1:0] i_mem_rdata,
   output logic                   o_core_rvalid,
   output logic [DATA_W-1:0]      o_core_rdata,
   output logic                   o_dbg_rvalid,
   output logic [DATA_W-1:0]      o_dbg_rdata
);
   logic              r_pending;
   owner_t            r_owner;
   logic [DATA_W-1:0] r_core_hold;
   logic [DATA_W-1:0] r_dbg_hold;
   logic              w_core_rvalid;
   logic              w_dbg_rvalid;

   assign w_core_rvalid = r_pending & (r_owner == OWN_CORE);
   assign w_dbg_rvalid  = r_pending & (r_owner == OWN_DBG);

   // Memory data is only valid during the return cycle, so pass it straight
   // through then and fall back to the held copy afterwards.
   assign o_core_rvalid = w_core_rvalid;
   assign o_dbg_rvalid  = w_dbg_rvalid;
   assign o_core_rdata  = w_core_rvalid ? i_mem_rdata : r_core_hold;
   assign o_dbg_rdata   = w_dbg_rvalid  ? i_mem_rdata : r_dbg_hold;

   // Track the outstanding read and capture delivered words per owner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending   <= 1'b0;
         r_owner     <= OWN_CORE;
         r_core_hold <= '0;
         r_dbg_hold  <= '0;
      end else begin
         r_pending <= i_rd_issue;
         if (i_rd_issue) begin
            r_owner <= i_rd_owner;
         end
         if (w_core_rvalid) begin
            r_core_hold <= i_mem_rdata;
         end
         if (w_dbg_rvalid) begin
            r_dbg_hold <= i_mem_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mu0_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mu0_mem_arbiter
//  Brief    : Shares MU0_Memory port 0 between the MU0 core and a debug host.
//             Cycle-by-cycle round-robin or debug-priority arbitration with a
//             core starvation bound, locked host bursts with a forced core
//             slot, and a one-cycle read return to the issuing requester.
//  Revision : 1.0  initial release
// ============================================================================
module mu0_mem_arbiter
   import mu0_bus_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int DBG_PRIORITY = 0,   // 0 round-robin, 1 host wins ties
   parameter int MAX_WAIT     = 4,   // refusals before the core must win (>=1)
   parameter int LOCK_MAX     = 8    // locked host grants per forced core slot (>=1)
) (
   input  wire logic        Clk,
   input  wire logic        Reset,
   mu0_mem_arbiter_if.slave bus
);
   localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int c_LOCK_W = $clog2(LOCK_MAX + 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LIM = c_WAIT_W'(MAX_WAIT);
   localparam logic [c_LOCK_W-1:0] c_LOCK_LIM = c_LOCK_W'(LOCK_MAX);

   arb_state_t        r_state;
   logic              r_last_dbg;     // 1: host was served last, core wins next tie
   logic [c_WAIT_W-1:0] r_wait_cnt;
   logic [c_LOCK_W-1:0] r_lock_cnt;
   logic [ADDR_W-1:0] r_last_addr;
   logic [DATA_W-1:0] r_last_wdata;

   logic              w_core_win;
   logic              w_dbg_win;
   logic              w_core_gnt;
   logic              w_dbg_gnt;
   logic              w_rd_issue;
   owner_t            w_rd_owner;

   // Pick at most one winner from the live requests and the registered state
   always_comb begin
      w_core_win = 1'b0;
      w_dbg_win  = 1'b0;
      if (r_state == ST_DBG_LOCK) begin
         if (bus.core_req && (r_lock_cnt >= c_LOCK_LIM)) begin
            w_core_win = 1'b1;
         end else if (bus.dbg_req) begin
            w_dbg_win = 1'b1;
         end else if (bus.core_req) begin
            w_core_win = 1'b1;
         end
      end else if (bus.core_req && bus.dbg_req) begin
         if (DBG_PRIORITY != 0) begin
            if (r_wait_cnt >= c_WAIT_LIM) begin
               w_core_win = 1'b1;
            end else begin
               w_dbg_win = 1'b1;
            end
         end else if (r_last_dbg) begin
            w_core_win = 1'b1;
         end else begin
            w_dbg_win = 1'b1;
         end
      end else begin
         w_core_win = bus.core_req;
         w_dbg_win  = bus.dbg_req;
      end
   end

   // Reset is asynchronous, so the combinational grants are held off while it
   // is asserted to keep every output quiet during reset.
   assign w_core_gnt = w_core_win & ~Reset;
   assign w_dbg_gnt  = w_dbg_win  & ~Reset;

   assign bus.core_gnt   = w_core_gnt;
   assign bus.dbg_gnt    = w_dbg_gnt;
   assign bus.core_stall = bus.core_req & ~w_core_gnt & ~Reset;

   assign bus.mem_addr  = w_core_gnt ? bus.core_addr  :
                          w_dbg_gnt  ? bus.dbg_addr   : r_last_addr;
   assign bus.mem_wdata = w_core_gnt ? bus.core_wdata :
                          w_dbg_gnt  ? bus.dbg_wdata  : r_last_wdata;
   assign bus.mem_we    = (w_core_gnt & bus.core_we) | (w_dbg_gnt & bus.dbg_we);

   assign w_rd_issue = (w_core_gnt & ~bus.core_we) | (w_dbg_gnt & ~bus.dbg_we);
   assign w_rd_owner = w_dbg_gnt ? OWN_DBG : OWN_CORE;

   // Ownership FSM with round-robin pointer, starvation and lock counters
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state      <= ST_IDLE;
         r_last_dbg   <= 1'b1;
         r_wait_cnt   <= '0;
         r_lock_cnt   <= '0;
         r_last_addr  <= '0;
         r_last_wdata <= '0;
      end else begin
         // Starvation counter: saturating count of refused core cycles
         if (w_core_win) begin
            r_wait_cnt <= '0;
         end else if (bus.core_req && (r_wait_cnt < c_WAIT_LIM)) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
         end

         if (w_core_win) begin
            r_last_addr  <= bus.core_addr;
            r_last_wdata <= bus.core_wdata;
            r_last_dbg   <= 1'b0;
            r_lock_cnt   <= '0;
            // A forced slot inside a still-locked burst returns to the lock
            if ((r_state == ST_DBG_LOCK) && bus.dbg_req && bus.dbg_lock) begin
               r_state <= ST_DBG_LOCK;
            end else begin
               r_state <= ST_CORE;
            end
         end else if (w_dbg_win) begin
            r_last_addr  <= bus.dbg_addr;
            r_last_wdata <= bus.dbg_wdata;
            r_last_dbg   <= 1'b1;
            if (bus.dbg_lock) begin
               r_state <= ST_DBG_LOCK;
               if (r_state != ST_DBG_LOCK) begin
                  r_lock_cnt <= c_LOCK_W'(1);
               end else if (r_lock_cnt < c_LOCK_LIM) begin
                  r_lock_cnt <= r_lock_cnt + c_LOCK_W'(1);
               end
            end else begin
               r_state    <= ST_DBG;
               r_lock_cnt <= '0;
            end
         end else begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
         end
      end
   end

   mu0_rd_return #(
      .DATA_W (DATA_W)
   ) u_rd_return (
      .clk           (Clk),
      .rst           (Reset),
      .i_rd_issue    (w_rd_issue),
      .i_rd_owner    (w_rd_owner),
      .i_mem_rdata   (bus.mem_rdata),
      .o_core_rvalid (bus.core_rvalid),
      .o_core_rdata  (bus.core_rdata),
      .o_dbg_rvalid  (bus.dbg_rvalid),
      .o_dbg_rdata   (bus.dbg_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_mu0_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mu0_mem_arbiter
//  Brief    : Directed self-checking bench. One arbiter in round-robin mode
//             and one in debug-priority mode, each with a registered-read
//             memory model on its port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mu0_mem_arbiter;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   mu0_mem_arbiter_if bus_rr ();
   mu0_mem_arbiter_if bus_pri ();

   mu0_mem_arbiter #(.DBG_PRIORITY(0), .MAX_WAIT(4), .LOCK_MAX(8)) u_dut_rr (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus_rr)
   );

   mu0_mem_arbiter #(.DBG_PRIORITY(1), .MAX_WAIT(4), .LOCK_MAX(8)) u_dut_pri (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus_pri)
   );

   // Registered-read memories: data appears the cycle after the address
   logic [15:0] mem_rr  [0:4095];
   logic [15:0] mem_pri [0:4095];

   always @(posedge Clk) begin
      if (bus_rr.mem_we) mem_rr[bus_rr.mem_addr] <= bus_rr.mem_wdata;
      bus_rr.mem_rdata <= mem_rr[bus_rr.mem_addr];
   end

   always @(posedge Clk) begin
      if (bus_pri.mem_we) mem_pri[bus_pri.mem_addr] <= bus_pri.mem_wdata;
      bus_pri.mem_rdata <= mem_pri[bus_pri.mem_addr];
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic rr_core(input logic req, input logic we, input logic [11:0] addr, input logic [15:0] wd);
      bus_rr.core_req = req; bus_rr.core_we = we; bus_rr.core_addr = addr; bus_rr.core_wdata = wd;
   endtask

   task automatic rr_dbg(input logic req, input logic we, input logic [11:0] addr, input logic [15:0] wd, input logic lock);
      bus_rr.dbg_req = req; bus_rr.dbg_we = we; bus_rr.dbg_addr = addr; bus_rr.dbg_wdata = wd; bus_rr.dbg_lock = lock;
   endtask

   task automatic pri_core(input logic req, input logic we, input logic [11:0] addr, input logic [15:0] wd);
      bus_pri.core_req = req; bus_pri.core_we = we; bus_pri.core_addr = addr; bus_pri.core_wdata = wd;
   endtask

   task automatic pri_dbg(input logic req, input logic we, input logic [11:0] addr, input logic [15:0] wd, input logic lock);
      bus_pri.dbg_req = req; bus_pri.dbg_we = we; bus_pri.dbg_addr = addr; bus_pri.dbg_wdata = wd; bus_pri.dbg_lock = lock;
   endtask

   task automatic check_rr_quiet(input string tag);
      check_val({tag, "_core_gnt"},    32'(bus_rr.core_gnt),    32'd0);
      check_val({tag, "_dbg_gnt"},     32'(bus_rr.dbg_gnt),     32'd0);
      check_val({tag, "_core_rvalid"}, 32'(bus_rr.core_rvalid), 32'd0);
      check_val({tag, "_dbg_rvalid"},  32'(bus_rr.dbg_rvalid),  32'd0);
      check_val({tag, "_core_rdata"},  32'(bus_rr.core_rdata),  32'd0);
      check_val({tag, "_dbg_rdata"},   32'(bus_rr.dbg_rdata),   32'd0);
      check_val({tag, "_mem_we"},      32'(bus_rr.mem_we),      32'd0);
      check_val({tag, "_mem_addr"},    32'(bus_rr.mem_addr),    32'd0);
      check_val({tag, "_mem_wdata"},   32'(bus_rr.mem_wdata),   32'd0);
      check_val({tag, "_core_stall"},  32'(bus_rr.core_stall),  32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k;
      int  prev;   // 0 none, 1 core, 2 host: owner of last cycle's read
      logic exp_core;
      logic exp_dbg;

      Reset = 1'b1;
      rr_core(1'b0, 1'b0, '0, '0);  rr_dbg(1'b0, 1'b0, '0, '0, 1'b0);
      pri_core(1'b0, 1'b0, '0, '0); pri_dbg(1'b0, 1'b0, '0, '0, 1'b0);

      // Quiet outputs under reset
      @(negedge Clk);
      check_rr_quiet("rst0");
      next_cycle();
      next_cycle();
      Reset = 1'b0;

      // Read of 0x010 interrupted by reset: no rvalid may follow
      next_cycle();
      rr_core(1'b1, 1'b0, 12'h010, '0);
      @(negedge Clk);
      check_val("rmr_gnt", 32'(bus_rr.core_gnt), 32'd1);
      next_cycle();
      rr_core(1'b0, 1'b0, '0, '0);
      Reset = 1'b1;
      @(negedge Clk);
      check_rr_quiet("rmr");
      next_cycle();
      Reset = 1'b0;
      @(negedge Clk);
      check_val("rmr_post_core_rvalid0", 32'(bus_rr.core_rvalid), 32'd0);
      check_val("rmr_post_dbg_rvalid0",  32'(bus_rr.dbg_rvalid),  32'd0);
      next_cycle();
      @(negedge Clk);
      check_val("rmr_post_core_rvalid1", 32'(bus_rr.core_rvalid), 32'd0);

      // Round-robin: core reads 0x001, host writes 0xBEEF to 0x800
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         rr_core(1'b1, 1'b0, 12'h001, '0);
         rr_dbg(1'b1, 1'b1, 12'h800, 16'hBEEF, 1'b0);
         @(negedge Clk);
         check_val($sformatf("rr_core_gnt%0d", i), 32'(bus_rr.core_gnt), 32'((i % 2) == 0));
         check_val($sformatf("rr_dbg_gnt%0d", i),  32'(bus_rr.dbg_gnt),  32'((i % 2) == 1));
         check_val($sformatf("rr_mem_we%0d", i),   32'(bus_rr.mem_we),   32'((i % 2) == 1));
         check_val($sformatf("rr_mem_addr%0d", i), 32'(bus_rr.mem_addr),
                   ((i % 2) == 1) ? 32'h800 : 32'h001);
      end
      next_cycle();
      rr_core(1'b0, 1'b0, '0, '0);
      rr_dbg(1'b0, 1'b0, '0, '0, 1'b0);

      // Host reads back 0x800
      next_cycle();
      rr_dbg(1'b1, 1'b0, 12'h800, '0, 1'b0);
      @(negedge Clk);
      check_val("rb800_gnt", 32'(bus_rr.dbg_gnt), 32'd1);
      next_cycle();
      rr_dbg(1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge Clk);
      check_val("rb800_dbg_rvalid",  32'(bus_rr.dbg_rvalid),  32'd1);
      check_val("rb800_dbg_rdata",   32'(bus_rr.dbg_rdata),   32'hBEEF);
      check_val("rb800_core_rvalid", 32'(bus_rr.core_rvalid), 32'd0);

      // Core-only write then read of 0x005
      next_cycle();
      rr_core(1'b1, 1'b1, 12'h005, 16'h1234);
      @(negedge Clk);
      check_val("cw_gnt",   32'(bus_rr.core_gnt),  32'd1);
      check_val("cw_we",    32'(bus_rr.mem_we),    32'd1);
      check_val("cw_addr",  32'(bus_rr.mem_addr),  32'h005);
      check_val("cw_wdata", 32'(bus_rr.mem_wdata), 32'h1234);
      next_cycle();
      rr_core(1'b1, 1'b0, 12'h005, '0);
      @(negedge Clk);
      check_val("cr_gnt",        32'(bus_rr.core_gnt),    32'd1);
      check_val("cr_addr",       32'(bus_rr.mem_addr),    32'h005);
      check_val("cr_we",         32'(bus_rr.mem_we),      32'd0);
      check_val("cw_no_rvalid",  32'(bus_rr.core_rvalid), 32'd0);
      check_val("cr_stall",      32'(bus_rr.core_stall),  32'd0);
      next_cycle();
      rr_core(1'b0, 1'b0, '0, '0);
      @(negedge Clk);
      check_val("cr_rvalid",     32'(bus_rr.core_rvalid), 32'd1);
      check_val("cr_rdata",      32'(bus_rr.core_rdata),  32'h1234);
      check_val("cr_dbg_rvalid", 32'(bus_rr.dbg_rvalid),  32'd0);
      check_val("cr_dbg_hold",   32'(bus_rr.dbg_rdata),   32'hBEEF);
      next_cycle();
      @(negedge Clk);
      check_val("idle_rvalid",    32'(bus_rr.core_rvalid), 32'd0);
      check_val("idle_rdata_hold", 32'(bus_rr.core_rdata), 32'h1234);
      check_val("idle_addr_hold", 32'(bus_rr.mem_addr),    32'h005);
      check_val("idle_we",        32'(bus_rr.mem_we),      32'd0);

      // Back-to-back reads alternating owners (core served last -> host first)
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         rr_core(1'b1, 1'b0, 12'h005, '0);
         rr_dbg(1'b1, 1'b0, 12'h800, '0, 1'b0);
         @(negedge Clk);
         check_val($sformatf("b2b_dbg_gnt%0d", i),     32'(bus_rr.dbg_gnt),     32'((i % 2) == 0));
         check_val($sformatf("b2b_core_rvalid%0d", i), 32'(bus_rr.core_rvalid), 32'(prev == 1));
         check_val($sformatf("b2b_dbg_rvalid%0d", i),  32'(bus_rr.dbg_rvalid),  32'(prev == 2));
         if (prev == 1) check_val($sformatf("b2b_core_rdata%0d", i), 32'(bus_rr.core_rdata), 32'h1234);
         if (prev == 2) check_val($sformatf("b2b_dbg_rdata%0d", i),  32'(bus_rr.dbg_rdata),  32'hBEEF);
         prev = ((i % 2) == 0) ? 2 : 1;
      end
      next_cycle();
      rr_core(1'b0, 1'b0, '0, '0);
      rr_dbg(1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge Clk);
      check_val("b2b_last_core_rvalid", 32'(bus_rr.core_rvalid), 32'd1);
      check_val("b2b_last_core_rdata",  32'(bus_rr.core_rdata),  32'h1234);
      check_val("b2b_last_dbg_rvalid",  32'(bus_rr.dbg_rvalid),  32'd0);

      // Debug priority with MAX_WAIT=4: four host grants then one core grant
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         pri_core(1'b1, 1'b0, 12'h001, '0);
         pri_dbg(1'b1, 1'b0, 12'h002, '0, 1'b0);
         @(negedge Clk);
         exp_core = ((i % 5) == 4);
         check_val($sformatf("pri_core_gnt%0d", i), 32'(bus_pri.core_gnt),   32'(exp_core));
         check_val($sformatf("pri_dbg_gnt%0d", i),  32'(bus_pri.dbg_gnt),    32'(!exp_core));
         check_val($sformatf("pri_stall%0d", i),    32'(bus_pri.core_stall), 32'(!exp_core));
      end
      next_cycle();
      pri_core(1'b0, 1'b0, '0, '0);
      pri_dbg(1'b0, 1'b0, '0, '0, 1'b0);

      // Locked burst of 10 writes from 0x100 with the core contending
      k = 0;
      for (int c = 0; c < 11; c++) begin
         next_cycle();
         pri_core(1'b1, 1'b0, 12'h001, '0);
         pri_dbg(1'b1, 1'b1, 12'(256 + k), 16'(16'hA000 + k), 1'b1);
         @(negedge Clk);
         exp_dbg = (c != 8);
         check_val($sformatf("lock_dbg_gnt%0d", c),  32'(bus_pri.dbg_gnt),  32'(exp_dbg));
         check_val($sformatf("lock_core_gnt%0d", c), 32'(bus_pri.core_gnt), 32'(!exp_dbg));
         if (bus_pri.dbg_gnt) begin
            check_val($sformatf("lock_addr%0d", c), 32'(bus_pri.mem_addr), 32'(256 + k));
            check_val($sformatf("lock_we%0d", c),   32'(bus_pri.mem_we),   32'd1);
            k++;
         end
      end
      check_val("lock_words_issued", 32'(k), 32'd10);

      // Core reads the burst back, one read per cycle
      for (int m = 0; m < 10; m++) begin
         next_cycle();
         pri_dbg(1'b0, 1'b0, '0, '0, 1'b0);
         pri_core(1'b1, 1'b0, 12'(256 + m), '0);
         @(negedge Clk);
         check_val($sformatf("rbk_gnt%0d", m), 32'(bus_pri.core_gnt), 32'd1);
         if (m > 0) begin
            check_val($sformatf("rbk_rvalid%0d", m), 32'(bus_pri.core_rvalid), 32'd1);
            check_val($sformatf("rbk_rdata%0d", m),  32'(bus_pri.core_rdata),  32'(16'hA000 + m - 1));
         end
      end
      next_cycle();
      pri_core(1'b0, 1'b0, '0, '0);
      @(negedge Clk);
      check_val("rbk_rvalid_last", 32'(bus_pri.core_rvalid), 32'd1);
      check_val("rbk_rdata_last",  32'(bus_pri.core_rdata),  32'hA009);
      check_val("rbk_dbg_rvalid",  32'(bus_pri.dbg_rvalid),  32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mu0_mem_arbiter.md
Name: mu0_mem_arbiter

Overview:
- Shares the single CPU-side port (port 0) of MU0_Memory between two requesters: the MU0 core and a debug/loader host.
- Arbitrates cycle by cycle and supports locked debug bursts with a forced-release bound.
- Returns read data with a one-cycle registered-read latency to whichever requester issued the read.
- Drives a stall indication so the core can be clock-enabled off while the host owns memory.

Parameters:
- ADDR_W, 12, address width in words.
- DATA_W, 16, data width.
- DBG_PRIORITY, 0: 0 = round-robin; 1 = debug has fixed priority, subject to the MAX_WAIT bound.
- MAX_WAIT, 4: in DBG_PRIORITY=1 mode, the number of consecutive cycles the core may be refused before it must win.
- LOCK_MAX, 8: maximum consecutive locked debug grants before one forced core slot.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- core_req  in  1  core requests a transfer this cycle.
- core_we  in  1  core write (1) / read (0).
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  core transfer issued this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_W  core read data.
- core_stall  out  1  core_req & ~core_gnt.
- dbg_req  in  1  host requests a transfer.
- dbg_we  in  1  host write/read.
- dbg_addr  in  ADDR_W  host address.
- dbg_wdata  in  DATA_W  host write data.
- dbg_lock  in  1  host asks to keep ownership for the next transfer.
- dbg_gnt  out  1  host transfer issued.
- dbg_rvalid  out  1  host read data valid.
- dbg_rdata  out  DATA_W  host read data.
- mem_addr  out  ADDR_W  to MU0_Memory address0.
- mem_wdata  out  DATA_W  to write_data0.
- mem_we  out  1  to WEn0.
- mem_rdata  in  DATA_W  from read_data0; valid the cycle after the address is presented.

Behaviour:
- Reset (asynchronous): all registered state clears; the FSM goes to IDLE and the round-robin pointer favours the core.
- Reset values: core_gnt=0, dbg_gnt=0, core_rvalid=0, dbg_rvalid=0, core_rdata=0, dbg_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Grant timing:
  - At most one grant per cycle.
  - gnt is combinational from the current req and the registered state.
  - The granted requester's addr/wdata/we are muxed onto mem_* in the same cycle.
  - mem_we = gnt & we.
- Idle bus: with no grant, mem_addr holds its last value and mem_we=0.
- Read return:
  - A granted read sets a registered pending flag plus an owner tag.
  - Next cycle, <owner>_rvalid=1 and <owner>_rdata=mem_rdata; the other requester's rdata holds its last value.
  - A granted write produces no rvalid.
  - Back-to-back reads give rvalid every cycle, in order.
- FSM states:
  - IDLE: no owner.
  - CORE: last grant went to the core.
  - DBG: last grant went to the host, unlocked.
  - DBG_LOCK: the host holds the bus.
- Arbitration, DBG_PRIORITY=0:
  - Only one requester asserting req → it wins.
  - Both asserting → the requester not served last wins; the pointer updates on every grant.
- Arbitration, DBG_PRIORITY=1:
  - The host wins ties.
  - A wait counter increments each cycle core_req is refused and clears on a core grant.
  - When the counter reaches MAX_WAIT, the core wins the next contested cycle.
- Lock:
  - A dbg grant with dbg_lock=1 enters DBG_LOCK.
  - In DBG_LOCK the core is refused while dbg_req=1.
  - A lock counter counts locked grants; after LOCK_MAX, the next cycle with core_req=1 grants the core once, then DBG_LOCK resumes if dbg_lock is still 1.
  - dbg_req=0 or dbg_lock=0 at a grant → leave DBG_LOCK and clear the lock counter.
- Idle bus: no req → no grant; the state moves to IDLE and the pointer is retained.
- Reset mid-read: the pending flag clears and no rvalid is emitted after Reset falls.
- Requester hold rule: a requester must keep req/addr/we/wdata stable until its gnt is seen; the arbiter does not buffer refused requests.

Decomposition:
- Shared package mu0_bus_pkg:
  - FSM state encoding (IDLE/CORE/DBG/DBG_LOCK).
  - Owner tag constants OWN_CORE / OWN_DBG.
  - ADDR_W/DATA_W defaults.
- Sub-module mu0_rd_return: pending flag, owner tag and rdata/rvalid steering. It keeps the return path separate from arbitration.

Test Plan:
- Reset asserted mid-read at 0x010: no rvalid after release; all outputs are 0 while Reset=1.
- Core-only read of 0x005 holding 0x1234: core_gnt same cycle, mem_addr=0x005; next cycle core_rvalid=1 and core_rdata=0x1234; dbg_rvalid stays 0.
- Round-robin, both requesting every cycle (core reads 0x001, host writes 0xBEEF to 0x800): grants alternate core/dbg/core/dbg; mem_we=1 only in the dbg cycles; 0x800 then reads back 0xBEEF.
- DBG_PRIORITY=1, MAX_WAIT=4, both requesting continuously: 4 dbg grants, then 1 core grant, repeating; core_stall high exactly on the refused cycles.
- Locked burst: host writes 10 words from 0x100 with dbg_lock=1, LOCK_MAX=8, core requesting: 8 dbg grants, 1 core grant, then 2 dbg grants; all 10 words read back correctly.
- Back-to-back reads alternating owners: each rvalid appears one cycle after its grant on the correct port, with no cross-delivery.
